seq_multi_adder: RTL

//  Parametrised multi-operand unsigned adder, the next generation of our 2-bit adder.

---
 rtl/seq_multi_adder.sv | 112 +++++++++++
 1 files changed

// File: rtl/seq_multi_adder.sv
// Serial multi-operand unsigned adder: one adder stepped over CHANNELS cycles, valid/ready on both sides.
// Build option: define SEQ_MULTI_ADDER_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module seq_multi_adder #(
    parameter int WIDTH    = 2,
    parameter int CHANNELS = 4,
    parameter int SUM_W    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH*CHANNELS-1:0] ops,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [SUM_W-1:0]          sum,
    output logic                      ovf,
    output logic                      out_valid,
    input  logic                      out_ready
);
    localparam int IDX_W = $clog2(CHANNELS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t                    state_reg;
    logic [WIDTH*CHANNELS-1:0] ops_reg;
    logic [SUM_W-1:0]          acc_reg;
    logic [SUM_W-1:0]          sum_reg;
    logic                      ovf_reg;
    logic                      out_valid_reg;
    logic                      in_ready_reg;
    logic [IDX_W-1:0]          idx_reg;

    logic [WIDTH-1:0]          op_arr [CHANNELS];
    logic [SUM_W:0]            add_full;
    logic                      carry;
    logic [SUM_W-1:0]          acc_next;
    logic                      ovf_next;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_op
            assign op_arr[gi] = ops_reg[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // The add is one bit wider than the accumulator so the carry out is visible as overflow.
    always_comb begin
        add_full = {1'b0, acc_reg} + {{(SUM_W + 1 - WIDTH){1'b0}}, op_arr[idx_reg]};
        carry    = add_full[SUM_W];
        ovf_next = ovf_reg | carry;
`ifdef SEQ_MULTI_ADDER_SAT_EN
        // Once saturated, the accumulator is pinned at full scale for the rest of the transaction.
        acc_next = (carry || ovf_reg) ? {SUM_W{1'b1}} : add_full[SUM_W-1:0];
`else
        acc_next = add_full[SUM_W-1:0];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            ops_reg       <= '0;
            acc_reg       <= '0;
            sum_reg       <= '0;
            ovf_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            idx_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        ops_reg      <= ops;
                        acc_reg      <= '0;
                        ovf_reg      <= 1'b0;
                        idx_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= ACC;
                    end
                end
                ACC: begin
                    acc_reg <= acc_next;
                    ovf_reg <= ovf_next;
                    idx_reg <= idx_reg + IDX_W'(1);
                    if (idx_reg == LAST_IDX) begin
                        sum_reg       <= acc_next;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    // sum_reg is left untouched so the last result stays visible in IDLE.
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign ovf       = ovf_reg;

endmodule
